// File: rtl/sample_loader_pkg.sv
// sample_loader_pkg: shared sizes, FSM state encodings and types for the
// sample loader. Optional feature macro: SAMPLE_LOADER_LABEL_EN (one extra
// class-label word per sample).
package sample_loader_pkg;

  localparam int DW = 16;  // data word width
  localparam int N  = 40;  // words per sample
  localparam int BM = 6;   // address width, ceil(log2(N))

`ifdef SAMPLE_LOADER_LABEL_EN
  localparam int FILL_WORDS = N + 1;  // sample words plus trailing label word
`else
  localparam int FILL_WORDS = N;
`endif

  typedef logic [DW-1:0] word_t;
  typedef logic [BM-1:0] addr_t;

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_FULL = 2'd1;
  localparam logic [1:0] ST_PUSH = 2'd2;

  localparam addr_t LAST_FILL = addr_t'(FILL_WORDS - 1);
  localparam addr_t LAST_PUSH = addr_t'(N - 1);

  // Counters only ever wrap from their last index back to zero.
  function automatic addr_t cnt_next(input addr_t cnt, input addr_t last);
    return (cnt == last) ? '0 : cnt + addr_t'(1);
  endfunction

endpackage

// File: rtl/sample_loader_if.sv
// sample_loader_if: host-side valid/ready word stream feeding the loader.
interface sample_loader_if;
  import sample_loader_pkg::*;

  word_t s_data;
  logic  s_valid;
  logic  s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/sample_loader_stage_buf.sv
// sample_loader_stage_buf: N x DW staging register file. One synchronous
// write port used while filling, one asynchronous read port used while
// bursting into the input memory. Contents are not reset.
module sample_loader_stage_buf
  import sample_loader_pkg::*;
(
  input  logic  clk,
  input  logic  wr_en,
  input  addr_t wr_addr,
  input  word_t wr_data,
  input  addr_t rd_addr,
  output word_t rd_data
);

  word_t mem [N];

  // capture host words; stale contents are harmless since every word is rewritten before use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_loader.sv
// sample_loader: accepts one sample from the host stream into a staging
// buffer, then bursts it into the input memory one word per cycle when the
// engine raises request_in. Optional feature macro: SAMPLE_LOADER_LABEL_EN
// adds a trailing label word per sample and the label_out/label_valid ports.
//
// state | meaning
// FILL  | accepting host words into the staging buffer
// FULL  | sample complete, waiting for an engine request
// PUSH  | streaming the staged sample into the input memory
module sample_loader
  import sample_loader_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  sample_loader_if.slave host,
  input  logic           request_in,
  output addr_t          wr_addr,
  output word_t          wr_data,
  output logic           wren_IN,
  output logic           load_done,
  output logic           underrun
`ifdef SAMPLE_LOADER_LABEL_EN
  ,
  output word_t          label_out,
  output logic           label_valid
`endif
);

  logic [1:0] state;
  addr_t      fill_cnt;
  addr_t      push_cnt;
  logic       req_q;
  logic       req_pend;
  logic       req_edge;
  logic       accept;
  logic       buf_wr_en;
  logic       push_last;
  word_t      rd_data;

  assign req_edge  = request_in && !req_q;
  assign host.s_ready = (state == ST_FILL) && !rst;
  assign accept    = host.s_valid && host.s_ready;
  // the label word (index N) never lands in the staging buffer
  assign buf_wr_en = accept && (fill_cnt <= LAST_PUSH);
  assign push_last = (state == ST_PUSH) && (push_cnt == LAST_PUSH);

  sample_loader_stage_buf u_stage_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_addr (fill_cnt),
    .wr_data (host.s_data),
    .rd_addr (push_cnt),
    .rd_data (rd_data)
  );

  // request edge detection, pending flag and sticky underrun
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q    <= 1'b0;
      req_pend <= 1'b0;
      underrun <= 1'b0;
    end else begin
      req_q <= request_in;
      if (req_edge && req_pend) begin
        underrun <= 1'b1;
      end
      // an edge arriving on the launch cycle is consumed by that launch
      if (state == ST_FULL && (req_pend || req_edge)) begin
        req_pend <= 1'b0;
      end else if (req_edge) begin
        req_pend <= 1'b1;
      end
    end
  end

  // sequencing FSM with fill and push counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_FILL;
      fill_cnt <= '0;
      push_cnt <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            fill_cnt <= cnt_next(fill_cnt, LAST_FILL);
            if (fill_cnt == LAST_FILL) begin
              state <= ST_FULL;
            end
          end
        end
        ST_FULL: begin
          if (req_pend || req_edge) begin
            state    <= ST_PUSH;
            push_cnt <= '0;
          end
        end
        ST_PUSH: begin
          push_cnt <= cnt_next(push_cnt, LAST_PUSH);
          if (push_cnt == LAST_PUSH) begin
            state <= ST_FILL;
          end
        end
        default: begin
          state <= ST_FILL;
        end
      endcase
    end
  end

  // registered input-memory write port; address and data hold between bursts
  always_ff @(posedge clk) begin
    if (rst) begin
      wren_IN   <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
    end else begin
      wren_IN   <= (state == ST_PUSH);
      load_done <= push_last;
      if (state == ST_PUSH) begin
        wr_addr <= push_cnt;
        wr_data <= rd_data;
      end
    end
  end

`ifdef SAMPLE_LOADER_LABEL_EN
  word_t label_stage;

  // hold the trailing label word and publish it alongside the last write
  always_ff @(posedge clk) begin
    if (rst) begin
      label_stage <= '0;
      label_out   <= '0;
      label_valid <= 1'b0;
    end else begin
      label_valid <= push_last;
      if (accept && fill_cnt == addr_t'(N)) begin
        label_stage <= host.s_data;
      end
      if (push_last) begin
        label_out <= label_stage;
      end
    end
  end
`endif

endmodule
